ahb_addr_gen: RTL and testbench
===============================

# ahb_addr_gen

Address and transfer-count generator for the AHB image interface of the edge-detection core. It sits directly downstream of the AHB controller FSM. It consumes the controller's read and write enable strobes and produces the three byte addresses for each 3x3 read window and the output-word write address. It also returns the `transfer_*_complete_*` and `end_of_image` status signals that steer the controller's state transitions.

## Interface
Parameters:
- `IMG_WIDTH`, 640, image width in bytes (1 byte/pixel); (IMG_WIDTH-4) must be divisible by COL_STEP
- `IMG_HEIGHT`, 480, image height in rows, ≥3
- `COL_STEP`, 2, byte advance of the read window column per window
- `SHIFT_CYCLES`, 4, shift cycles per fetched 32-bit word
- `READ_BASE`, 32'h0000_0000, source image base address
- `WRITE_BASE`, 32'h0010_0000, result buffer base address

Ports:
- `HCLK`  in  1  system clock, all state on rising edge
- `HRESET`  in  1  asynchronous, active-high reset
- `addr_enable_r`  in  1  controller in READ_ADDR_k
- `shift_enable_r`  in  1  controller in SHIFT_k
- `addr_update_enable_r`  in  1  advance read window
- `addr_enable_w`  in  1  controller in WRITE_ADDR
- `shift_enable_w`  in  1  controller in WRITE_DATA
- `addr_update_enable_w`  in  1  advance write pointer
- `haddr_r`  out  32  current read address
- `haddr_w`  out  32  current write address
- `transfer_addr_complete_r`  out  1  registered echo of addr_enable_r
- `transfer_data_complete_r`  out  1  current word fully shifted
- `transfer_addr_complete_w`  out  1  registered echo of addr_enable_w
- `transfer_data_complete_w`  out  1  registered echo of shift_enable_w
- `end_of_image`  out  1  last window read / last word written

## Operation
- Derived constants:
  - NCOL = (IMG_WIDTH-4)/COL_STEP + 1
  - NROW = IMG_HEIGHT-2
  - TOTAL = NCOL*NROW windows; one output word per window
- Read state:
  - `col` (byte offset); `row_off` (= row*IMG_WIDTH, kept by addition, no multiplier); `row` count; `ridx` 0..2; `shift_cnt` 0..SHIFT_CYCLES-1; sticky `read_done`.
  - `haddr_r` = READ_BASE + row_off + {0, IMG_WIDTH, 2*IMG_WIDTH}[ridx] + col.
  - `shift_enable_r` high: shift_cnt increments. At SHIFT_CYCLES-1, `transfer_data_complete_r` = 1 combinationally, shift_cnt → 0 and ridx advances 0→1→2→0.
  - `addr_update_enable_r` (ignored when read_done):
    - if col+COL_STEP ≤ IMG_WIDTH-4: col += COL_STEP
    - else: col = 0, row_off += IMG_WIDTH, row += 1
- Last window is row==NROW-1 and col==IMG_WIDTH-4. At ridx==2 completion of the last window, `end_of_image` and `transfer_data_complete_r` are both 1 in the same cycle; the controller prioritises end_of_image. read_done sets on the next edge.
- Write state:
  - `wcnt` 0..TOTAL-1; `haddr_w` = WRITE_BASE + 4*wcnt; sticky `write_done`.
  - `addr_update_enable_w`: wcnt += 1, saturating at TOTAL-1; ignored when write_done.
  - `shift_enable_w` with wcnt==TOTAL-1: end_of_image = 1; write_done sets on the next edge.
- end_of_image = read-last term | write-last term | write_done.
- Read and write paths are independent. Simultaneous read and write strobes are each applied; no priority between them.

## Timing
- Reset values (asynchronous, immediate on HRESET=1):
  - all counters and flags 0
  - `haddr_r` = READ_BASE, `haddr_w` = WRITE_BASE
  - all complete outputs and end_of_image 0
- Reset mid-window discards progress; the first read after reset is READ_BASE.
- `haddr_r`/`haddr_w` are combinational from registers. They are valid in the same cycle as addr_enable_* and change only on the edge after an update strobe or a ridx advance.
- `transfer_addr_complete_*` and `transfer_data_complete_w`: 1-cycle registered latency.
- `transfer_data_complete_r`: 0 latency; asserted in the SHIFT_CYCLES-th consecutive shift_enable_r cycle.
- If shift_enable_r drops before completion, shift_cnt holds; it is not cleared.

## Test plan
Bench parameters: IMG_WIDTH=8, IMG_HEIGHT=4, COL_STEP=2, SHIFT_CYCLES=4, READ_BASE=0x100, WRITE_BASE=0x800 (NCOL=3, NROW=2, TOTAL=6).
- Reset, then one window (3 × addr/shift-4): haddr_r = 0x100, 0x108, 0x110. transfer_data_complete_r pulses on the 4th shift cycle of each word, never earlier. ridx returns to 0.
- Three addr_update_enable_r pulses: window columns 0, 2, 4, then wrap to col 0 of row 1. First address 0x108.
- Full read of 6 windows: end_of_image = 1 exactly on the 4th shift cycle of ridx 2 of window 5 (addresses 0x10C/0x114/0x11C). A further addr_update_enable_r leaves haddr_r unchanged.
- Write path, 6 × (addr_enable_w, shift_enable_w, addr_update_enable_w): haddr_w = 0x800…0x814. end_of_image rises with shift_enable_w at 0x814 and stays 1 afterwards.
- Drop shift_enable_r for 3 cycles after 2 shift cycles: completion occurs after 2 more shift cycles (4 total), not earlier.
- Assert HRESET mid-window (ridx=1, shift_cnt=2, wcnt=3): all outputs return to reset values in the same cycle; the next window starts at 0x100 and writes resume at 0x800.

Source files
------------

// File: rtl/ahb_addr_gen.sv
// Address and transfer-count generator for the AHB image interface.
// Produces the three row addresses of each 3x3 read window, the output-word
// write address, and the completion/end-of-image status for the controller.
module ahb_addr_gen #(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned COL_STEP     = 2,
    parameter int unsigned SHIFT_CYCLES = 4,
    parameter logic [31:0] READ_BASE    = 32'h0000_0000,
    parameter logic [31:0] WRITE_BASE   = 32'h0010_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        addr_enable_r,
    input  logic        shift_enable_r,
    input  logic        addr_update_enable_r,
    input  logic        addr_enable_w,
    input  logic        shift_enable_w,
    input  logic        addr_update_enable_w,
    output logic [31:0] haddr_r,
    output logic [31:0] haddr_w,
    output logic        transfer_addr_complete_r,
    output logic        transfer_data_complete_r,
    output logic        transfer_addr_complete_w,
    output logic        transfer_data_complete_w,
    output logic        end_of_image
);

    localparam int unsigned NCOL     = (IMG_WIDTH - 4) / COL_STEP + 1;
    localparam int unsigned NROW     = IMG_HEIGHT - 2;
    localparam int unsigned TOTAL    = NCOL * NROW;
    localparam logic [31:0] LAST_COL = 32'(IMG_WIDTH - 4);
    localparam logic [31:0] LAST_ROW = 32'(NROW - 1);
    localparam logic [31:0] LAST_W   = 32'(TOTAL - 1);
    localparam logic [31:0] LAST_SH  = 32'(SHIFT_CYCLES - 1);
    localparam logic [31:0] WIDTH32  = 32'(IMG_WIDTH);
    localparam logic [31:0] STEP32   = 32'(COL_STEP);

    // Read-side state
    logic [31:0] col_q, col_d;
    logic [31:0] row_off_q, row_off_d;
    logic [31:0] row_q, row_d;
    logic [1:0]  ridx_q, ridx_d;
    logic [31:0] shift_cnt_q, shift_cnt_d;
    logic        read_done_q, read_done_d;

    // Write-side state
    logic [31:0] wcnt_q, wcnt_d;
    logic        write_done_q, write_done_d;

    // Registered echoes of controller strobes
    logic        addr_cmp_r_q, addr_cmp_w_q, data_cmp_w_q;

    logic        shift_last;
    logic        read_last;
    logic        write_last;
    logic [31:0] ridx_off;

    // Word-level completion and end-of-image detection
    always_comb begin
        shift_last = shift_enable_r && (shift_cnt_q == LAST_SH);
        read_last  = shift_last && (ridx_q == 2'd2) && (row_q == LAST_ROW) &&
                     (col_q == LAST_COL);
        write_last = shift_enable_w && (wcnt_q == LAST_W);
    end

    // Row-within-window offset selected by the current word index
    always_comb begin
        ridx_off = '0;
        unique case (ridx_q)
            2'd0:    ridx_off = '0;
            2'd1:    ridx_off = WIDTH32;
            default: ridx_off = WIDTH32 << 1;
        endcase
    end

    // Read-side next state: shift counting, word index and window advance
    always_comb begin
        col_d       = col_q;
        row_off_d   = row_off_q;
        row_d       = row_q;
        ridx_d      = ridx_q;
        shift_cnt_d = shift_cnt_q;
        read_done_d = read_done_q;

        if (shift_enable_r) begin
            if (shift_last) begin
                shift_cnt_d = '0;
                ridx_d      = (ridx_q == 2'd2) ? 2'd0 : ridx_q + 2'd1;
            end else begin
                shift_cnt_d = shift_cnt_q + 32'd1;
            end
        end

        if (addr_update_enable_r && !read_done_q) begin
            if (col_q + STEP32 <= LAST_COL) begin
                col_d = col_q + STEP32;
            end else begin
                col_d     = '0;
                row_off_d = row_off_q + WIDTH32;
                row_d     = row_q + 32'd1;
            end
        end

        if (read_last) begin
            read_done_d = 1'b1;
        end
    end

    // Write-side next state: saturating word counter
    always_comb begin
        wcnt_d       = wcnt_q;
        write_done_d = write_done_q;
        if (addr_update_enable_w && !write_done_q && (wcnt_q != LAST_W)) begin
            wcnt_d = wcnt_q + 32'd1;
        end
        if (write_last) begin
            write_done_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            col_q        <= '0;
            row_off_q    <= '0;
            row_q        <= '0;
            ridx_q       <= '0;
            shift_cnt_q  <= '0;
            read_done_q  <= 1'b0;
            wcnt_q       <= '0;
            write_done_q <= 1'b0;
            addr_cmp_r_q <= 1'b0;
            addr_cmp_w_q <= 1'b0;
            data_cmp_w_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_off_q    <= row_off_d;
            row_q        <= row_d;
            ridx_q       <= ridx_d;
            shift_cnt_q  <= shift_cnt_d;
            read_done_q  <= read_done_d;
            wcnt_q       <= wcnt_d;
            write_done_q <= write_done_d;
            addr_cmp_r_q <= addr_enable_r;
            addr_cmp_w_q <= addr_enable_w;
            data_cmp_w_q <= shift_enable_w;
        end
    end

    // Outputs: addresses are combinational from registered state
    always_comb begin
        haddr_r                  = READ_BASE + row_off_q + ridx_off + col_q;
        haddr_w                  = WRITE_BASE + (wcnt_q << 2);
        transfer_addr_complete_r = addr_cmp_r_q;
        transfer_data_complete_r = shift_last;
        transfer_addr_complete_w = addr_cmp_w_q;
        transfer_data_complete_w = data_cmp_w_q;
        end_of_image             = read_last | write_last | write_done_q;
    end

endmodule

// File: tb/tb_ahb_addr_gen.sv
// Self-checking bench for ahb_addr_gen: directed scenarios plus a random phase,
// every cycle compared against a window/word-level reference model.
module tb_ahb_addr_gen;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 4;
    localparam int unsigned STEP = 2;
    localparam int unsigned SC   = 4;
    localparam int unsigned RB   = 32'h100;
    localparam int unsigned WB   = 32'h800;
    localparam int unsigned NCOL = (W - 4) / STEP + 1;
    localparam int unsigned NROW = H - 2;
    localparam int unsigned TOT  = NCOL * NROW;

    logic        HCLK;
    logic        HRESET;
    logic        addr_enable_r, shift_enable_r, addr_update_enable_r;
    logic        addr_enable_w, shift_enable_w, addr_update_enable_w;
    logic [31:0] haddr_r, haddr_w;
    logic        transfer_addr_complete_r, transfer_data_complete_r;
    logic        transfer_addr_complete_w, transfer_data_complete_w;
    logic        end_of_image;

    ahb_addr_gen #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .COL_STEP    (STEP),
        .SHIFT_CYCLES(SC),
        .READ_BASE   (32'h100),
        .WRITE_BASE  (32'h800)
    ) dut (
        .HCLK                    (HCLK),
        .HRESET                  (HRESET),
        .addr_enable_r           (addr_enable_r),
        .shift_enable_r          (shift_enable_r),
        .addr_update_enable_r    (addr_update_enable_r),
        .addr_enable_w           (addr_enable_w),
        .shift_enable_w          (shift_enable_w),
        .addr_update_enable_w    (addr_update_enable_w),
        .haddr_r                 (haddr_r),
        .haddr_w                 (haddr_w),
        .transfer_addr_complete_r(transfer_addr_complete_r),
        .transfer_data_complete_r(transfer_data_complete_r),
        .transfer_addr_complete_w(transfer_addr_complete_w),
        .transfer_data_complete_w(transfer_data_complete_w),
        .end_of_image            (end_of_image)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: window number, word within window, shifts into word
    int unsigned m_win, m_word, m_shift, m_wcnt;
    bit          m_rdone, m_wdone;
    bit          p_ar, p_aw, p_sw;
    logic        obs_eoi, obs_tdc_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_word = 0; m_shift = 0; m_wcnt = 0;
        m_rdone = 0; m_wdone = 0;
        p_ar = 0; p_aw = 0; p_sw = 0;
    endtask

    // One clock: drive strobes, check all outputs mid-cycle, advance model at the edge
    task automatic cycle(input bit ar, input bit sr, input bit ur,
                         input bit aw, input bit sw, input bit uw);
        int unsigned e_hr, e_hw;
        bit          e_tdc, e_rlast, e_wlast, e_eoi;
        addr_enable_r = ar; shift_enable_r = sr; addr_update_enable_r = ur;
        addr_enable_w = aw; shift_enable_w = sw; addr_update_enable_w = uw;
        @(negedge HCLK);
        e_hr    = RB + (m_win / NCOL) * W + m_word * W + (m_win % NCOL) * STEP;
        e_hw    = WB + 4 * m_wcnt;
        e_tdc   = sr && (m_shift == SC - 1);
        e_rlast = e_tdc && (m_word == 2) && (m_win == TOT - 1);
        e_wlast = sw && (m_wcnt == TOT - 1);
        e_eoi   = e_rlast || e_wlast || m_wdone;
        check("haddr_r", haddr_r, e_hr);
        check("haddr_w", haddr_w, e_hw);
        check("tdc_r", 32'(transfer_data_complete_r), 32'(e_tdc));
        check("tac_r", 32'(transfer_addr_complete_r), 32'(p_ar));
        check("tac_w", 32'(transfer_addr_complete_w), 32'(p_aw));
        check("tdc_w", 32'(transfer_data_complete_w), 32'(p_sw));
        check("eoi", 32'(end_of_image), 32'(e_eoi));
        obs_eoi   = end_of_image;
        obs_tdc_r = transfer_data_complete_r;
        @(posedge HCLK);
        if (sr) begin
            if (m_shift == SC - 1) begin
                m_shift = 0;
                m_word  = (m_word + 1) % 3;
            end else begin
                m_shift++;
            end
        end
        if (ur && !m_rdone) m_win++;
        if (e_rlast) m_rdone = 1;
        if (uw && !m_wdone && m_wcnt < TOT - 1) m_wcnt++;
        if (e_wlast) m_wdone = 1;
        p_ar = ar; p_aw = aw; p_sw = sw;
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_haddr_r", haddr_r, RB);
        check("rst_haddr_w", haddr_w, WB);
        check("rst_tac_r", 32'(transfer_addr_complete_r), 32'd0);
        check("rst_tdc_r", 32'(transfer_data_complete_r), 32'd0);
        check("rst_tac_w", 32'(transfer_addr_complete_w), 32'd0);
        check("rst_tdc_w", 32'(transfer_data_complete_w), 32'd0);
        check("rst_eoi", 32'(end_of_image), 32'd0);
    endtask

    // Reset is raised between edges so its asynchronous effect is visible at once
    task automatic do_reset();
        addr_enable_r = 0; shift_enable_r = 0; addr_update_enable_r = 0;
        addr_enable_w = 0; shift_enable_w = 0; addr_update_enable_w = 0;
        HRESET = 1'b1;
        #1;
        check_reset_values();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();
    endtask

    task automatic read_word();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(SC); i++) cycle(0, 1, 0, 0, 0, 0);
    endtask

    task automatic read_window();
        for (int k = 0; k < 3; k++) read_word();
    endtask

    initial begin
        HRESET = 1'b1;
        model_reset();
        #2;
        do_reset();

        // One window: word addresses 0x100/0x108/0x110, ridx wraps to 0
        cycle(1, 0, 0, 0, 0, 0);
        check("win0_w0", haddr_r, 32'h108 - 32'h8);
        for (int i = 0; i < int'(SC); i++) cycle(0, 1, 0, 0, 0, 0);
        check("win0_w1", haddr_r, 32'h108);
        read_word();
        check("win0_w2", haddr_r, 32'h110);
        read_word();
        check("win0_ridx0", haddr_r, 32'h100);

        // Three column advances wrap into row 1
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
        check("row1_col0", haddr_r, 32'h108);

        // Full read of all windows; end_of_image on last word's final shift
        do_reset();
        for (int w = 0; w < int'(TOT); w++) begin
            read_window();
            if (w != int'(TOT) - 1) cycle(0, 0, 1, 0, 0, 0);
        end
        check("read_eoi", 32'(obs_eoi), 32'd1);
        cycle(0, 0, 1, 0, 0, 0);
        check("read_done_hold", haddr_r, 32'h10C);
        cycle(0, 0, 0, 0, 0, 0);

        // Write path: 0x800..0x814 then sticky end_of_image
        do_reset();
        for (int i = 0; i < int'(TOT); i++) begin
            cycle(0, 0, 0, 1, 0, 0);
            check("haddr_w_seq", haddr_w, 32'(WB + 4 * i));
            cycle(0, 0, 0, 0, 1, 0);
            cycle(0, 0, 0, 0, 0, 1);
        end
        check("write_eoi_sticky", 32'(end_of_image), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        check("write_eoi_hold", 32'(end_of_image), 32'd1);

        // Stalled shift: completion only on the 4th actual shift cycle
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("stall_no_early", 32'(obs_tdc_r), 32'd0);
        cycle(0, 1, 0, 0, 0, 0);
        check("stall_complete", 32'(obs_tdc_r), 32'd1);

        // Reset mid-window with writes in flight
        do_reset();
        read_word();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 1, 0);
            cycle(0, 0, 0, 0, 0, 1);
        end
        check("pre_rst_haddr_r", haddr_r, 32'h108);
        check("pre_rst_haddr_w", haddr_w, 32'h80C);
        do_reset();
        read_word();
        cycle(0, 0, 0, 1, 0, 0);

        // Random strobes against the model, interrupted by occasional resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (($urandom % 150) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom % 4 == 0), 1'($urandom % 4 != 0), 1'($urandom % 6 == 0),
                      1'($urandom % 3 == 0), 1'($urandom % 3 == 0), 1'($urandom % 5 == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
